// File: rtl/divider_pkg.sv
// divider_pkg: shared types and helpers for the divider_hs slice.
//   div_state_t : controller states (IDLE, CALC, FIXUP, DONE)
//   cond_neg    : conditional two's-complement negation, used for both |x|
//                 and result sign restoration. Operands up to MAX_W bits are
//                 zero-extended in and truncated back out by the caller; the
//                 low bits of the negation are the same at any width.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v,
                                                  input logic             en);
        return en ? (~v + MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/divider_hs_if.sv
// divider_hs_if: request/response handshake bundle for divider_hs.
//   master : requester/consumer side (drives operands and out_ready)
//   slave  : divider side (drives in_ready and the result)
interface divider_hs_if #(
    parameter int DIVIDEND_WIDTH = 64,
    parameter int DIVISOR_WIDTH  = 32
) ();
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_signed;
    logic [DIVIDEND_WIDTH-1:0] dividend;
    logic [DIVISOR_WIDTH-1:0]  divisor;
    logic                      out_valid;
    logic                      out_ready;
    logic [DIVIDEND_WIDTH-1:0] quotient;
    logic [DIVISOR_WIDTH-1:0]  remainder;
    logic                      div_by_zero;
    logic                      overflow;

    modport master (
        output in_valid, in_signed, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, in_signed, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
//   rem_in  : partial remainder (always < divisor)
//   bit_in  : next dividend bit shifted into the trial value
//   divisor : divisor magnitude
//   rem_out : new partial remainder
//   q_bit   : quotient bit resolved by this step
module div_step #(
    parameter int DIVISOR_WIDTH = 32
) (
    input  logic [DIVISOR_WIDTH-1:0] rem_in,
    input  logic                     bit_in,
    input  logic [DIVISOR_WIDTH-1:0] divisor,
    output logic [DIVISOR_WIDTH-1:0] rem_out,
    output logic                     q_bit
);
    logic [DIVISOR_WIDTH:0] trial;
    logic [DIVISOR_WIDTH:0] diff;

    assign trial = {rem_in, bit_in};
    assign diff  = trial - {1'b0, divisor};
    assign q_bit = (trial >= {1'b0, divisor});
    // trial < 2*divisor, so either choice fits back into DIVISOR_WIDTH bits
    assign rem_out = DIVISOR_WIDTH'(q_bit ? diff : trial);
endmodule

// File: rtl/divider_hs.sv
// divider_hs: multi-cycle restoring divider, signed/unsigned per request,
// BITS_PER_CYCLE quotient bits per CALC cycle, valid/ready on both sides.
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : divider_hs_if slave (request operands in, result + flags out)
// Divide-by-zero and signed overflow bypass CALC and complete at accept.
module divider_hs
    import divider_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = 64,
    parameter int DIVISOR_WIDTH  = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic         clock,
    input  logic         reset,
    divider_hs_if.slave  bus
);
    localparam int NW = DIVIDEND_WIDTH;
    localparam int DW = DIVISOR_WIDTH;
    localparam int B  = BITS_PER_CYCLE;
    localparam int K  = NW / B;
    localparam int CW = $clog2(K + 1);
    localparam logic [NW-1:0] MOST_NEG = {1'b1, {(NW-1){1'b0}}};

    div_state_t      state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [NW-1:0]   work_q, work_d;        // dividend shifts out MSB-first, quotient shifts in
    logic [DW-1:0]   rem_q, rem_d;
    logic [DW-1:0]   dsr_q, dsr_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [NW-1:0]   quo_q, quo_d;
    logic [DW-1:0]   remo_q, remo_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;

    logic            dvd_neg, dsr_neg;
    logic [B:0][DW-1:0] rem_chain;
    logic [B-1:0]    q_bits;

    assign dvd_neg = bus.in_signed & bus.dividend[NW-1];
    assign dsr_neg = bus.in_signed & bus.divisor[DW-1];

    assign rem_chain[0] = rem_q;
    for (genvar i = 0; i < B; i++) begin : g_step
        div_step #(.DIVISOR_WIDTH(DW)) u_step (
            .rem_in  (rem_chain[i]),
            .bit_in  (work_q[NW-1-i]),
            .divisor (dsr_q),
            .rem_out (rem_chain[i+1]),
            .q_bit   (q_bits[B-1-i])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            work_q    <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quo_q     <= '0;
            remo_q    <= '0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            work_q    <= work_d;
            rem_q     <= rem_d;
            dsr_q     <= dsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            quo_q     <= quo_d;
            remo_q    <= remo_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        work_d    = work_q;
        rem_d     = rem_q;
        dsr_d     = dsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        quo_d     = quo_q;
        remo_d    = remo_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    work_d    = NW'(cond_neg(MAX_W'(bus.dividend), dvd_neg));
                    dsr_d     = DW'(cond_neg(MAX_W'(bus.divisor), dsr_neg));
                    neg_quo_d = dvd_neg ^ dsr_neg;
                    neg_rem_d = dvd_neg;
                    count_d   = CW'(K);
                    rem_d     = '0;
                    if (bus.divisor == '0) begin
                        quo_d   = '1;
                        remo_d  = bus.dividend[DW-1:0];
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = DONE;
                    end else if (bus.in_signed && bus.dividend == MOST_NEG &&
                                 bus.divisor == '1) begin
                        quo_d   = MOST_NEG;
                        remo_d  = '0;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d   = rem_chain[B];
                work_d  = {work_q[NW-B-1:0], q_bits};
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                quo_d   = NW'(cond_neg(MAX_W'(work_q), neg_quo_q));
                // truncating division: remainder follows the dividend's sign
                remo_d  = DW'(cond_neg(MAX_W'(rem_q), neg_rem_q && (rem_q != '0)));
                dbz_d   = 1'b0;
                ovf_d   = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready    = (state_q == IDLE) && !reset;
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = remo_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule
